// File: rtl/add_pipe_rv.sv
// add_pipe_rv: pipelined adder with carry-out, STAGES valid/ready slots and bubble collapse.
// Optional INPUT_FLOPS_EN adds a registered operand slot ahead of the adder.
module add_pipe_rv #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              c,
  output logic                          c_carry,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);
  localparam int OW = $clog2(STAGES+2);
  logic [STAGES-1:0] v_q, v_d, rdy, v_src;
  logic [WIDTH:0]    d_q [STAGES];
  logic [WIDTH:0]    d_d [STAGES];
  logic [WIDTH:0]    sum;
  logic [OW-1:0]     occ_q, occ_d;
  logic              src_v;
`ifdef INPUT_FLOPS_EN
  logic              iv_q, iv_d, irdy;
  logic [WIDTH-1:0]  ia_q, ib_q, ia_d, ib_d;
  assign sum      = {1'b0, ia_q} + {1'b0, ib_q};
  assign src_v    = iv_q;
  assign irdy     = !iv_q | rdy[0];
  assign in_ready = irdy;
  always_comb begin
    iv_d = irdy ? in_valid : iv_q;
    ia_d = (irdy && in_valid) ? a : ia_q;
    ib_d = (irdy && in_valid) ? b : ib_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q <= 1'b0;
      ia_q <= '0;
      ib_q <= '0;
    end else begin
      iv_q <= iv_d;
      ia_q <= ia_d;
      ib_q <= ib_d;
    end
  end
`else
  assign sum      = {1'b0, a} + {1'b0, b};
  assign src_v    = in_valid;
  assign in_ready = rdy[0];
`endif
  // Ready propagates combinationally from the output back to slot 0
  always_comb begin
    rdy[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int k = STAGES-2; k >= 0; k--) rdy[k] = !v_q[k] | rdy[k+1];
  end
  always_comb begin
    v_src[0] = src_v;
    for (int k = 1; k < STAGES; k++) v_src[k] = v_q[k-1];
  end
  always_comb begin
    v_d   = v_q;
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      d_d[k] = d_q[k];
      if (rdy[k]) begin
        v_d[k] = v_src[k];
        if (v_src[k]) d_d[k] = (k == 0) ? sum : d_q[(k == 0) ? 0 : k-1];
      end
      occ_d = occ_d + OW'(v_d[k]);
    end
`ifdef INPUT_FLOPS_EN
    occ_d = occ_d + OW'(iv_d);
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < STAGES; k++) d_q[k] <= d_d[k];
    end
  end
  assign c         = d_q[STAGES-1][WIDTH-1:0];
  assign c_carry   = d_q[STAGES-1][WIDTH];
  assign out_valid = v_q[STAGES-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_add_pipe_rv.sv
// tb_add_pipe_rv: directed self-checking bench for add_pipe_rv (WIDTH=32, STAGES=2, default build).
module tb_add_pipe_rv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, c;
  logic        in_valid, in_ready, c_carry, out_valid, out_ready;
  logic [1:0]  occupancy;
  int          checks = 0;
  int          errors = 0;

  add_pipe_rv #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .c_carry(c_carry), .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv);
    in_valid = v;
    a = av;
    b = bv;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_carry", c_carry, 0);
    chk("rst_occ", occupancy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // streaming
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd7);
    chk("s_in_ready", in_ready, 1);
    step();
    drive(1'b1, 32'd1, 32'd2);
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("s_c12", c, 12);
    chk("s_v1", out_valid, 1);
    chk("s_carry0", c_carry, 0);
    chk("s_occ2", occupancy, 2);
    step();
    chk("s_c3", c, 3);
    chk("s_v2", out_valid, 1);
    chk("s_occ1", occupancy, 1);
    step();
    chk("s_empty", out_valid, 0);
    chk("s_occ0", occupancy, 0);

    // wrap
    drive(1'b1, 32'hFFFF_FFFF, 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("w_c", c, 0);
    chk("w_carry", c_carry, 1);
    chk("w_v", out_valid, 1);
    step();
    chk("w_drain", out_valid, 0);

    // full / backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd1);
    chk("f_rdy1", in_ready, 1);
    step();
    drive(1'b1, 32'd20, 32'd2);
    chk("f_rdy2", in_ready, 1);
    step();
    drive(1'b1, 32'd30, 32'd3);
    chk("f_rdy3", in_ready, 0);
    chk("f_occ", occupancy, 2);
    chk("f_c11", c, 11);
    step();
    drive(1'b1, 32'd40, 32'd4);
    chk("f_rdy4", in_ready, 0);
    chk("f_hold_c", c, 11);
    chk("f_hold_v", out_valid, 1);
    chk("f_occ_hold", occupancy, 2);
    step();

    // simultaneous in/out while full
    out_ready = 1'b1;
    drive(1'b1, 32'd40, 32'd4);
    chk("x_rdy", in_ready, 1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("x_c22", c, 22);
    chk("x_occ", occupancy, 2);
    step();
    chk("x_c44", c, 44);
    chk("x_occ1", occupancy, 1);
    step();
    chk("x_empty", out_valid, 0);
    chk("x_occ0", occupancy, 0);

    // bubble collapse
    out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("b_occ1", occupancy, 1);
    chk("b_c101", c, 101);
    drive(1'b1, 32'd7, 32'd8);
    chk("b_rdy", in_ready, 1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("b_occ2", occupancy, 2);
    chk("b_c_hold", c, 101);

    // asynchronous reset with two results held
    rst_n = 1'b0;
    #1;
    chk("ar_v", out_valid, 0);
    chk("ar_c", c, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_rdy", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_no_out", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
